// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard : in-flight destination scoreboard with D-stage stall,
//                     forwarding select, MDU busy window and stall counter.
// Revision 1.0
// ============================================================================
module hazard_scoreboard #(
  parameter int DEPTH       = 3,
  parameter int TNEW_W      = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        D_rs,
  input  logic [4:0]        D_rt,
  input  logic [TNEW_W-1:0] D_TuseRs,
  input  logic [TNEW_W-1:0] D_TuseRt,
  input  logic [4:0]        D_dst,
  input  logic              D_writeReg_EN,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic [1:0]        D_mduOp,
  output logic              stall,
  output logic [SEL_W-1:0]  fwdSelRs,
  output logic [SEL_W-1:0]  fwdSelRt,
  output logic              mduBusy,
  output logic [31:0]       stallCount
);

  localparam int C_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);
  localparam logic [TNEW_W-1:0] C_TUSE_NONE = {TNEW_W{1'b1}};
  localparam logic [1:0] C_MDU_MULT = 2'b01;
  localparam logic [1:0] C_MDU_DIV  = 2'b10;

  logic [DEPTH-1:0]  valid_q;
  logic [4:0]        addr_q [DEPTH];
  logic [TNEW_W-1:0] tnew_q [DEPTH];
  logic [1:0]        mdu_q;
  logic [C_CNT_W-1:0] busy_q, busy_d;
  logic [31:0]       stall_cnt_q;

  logic              hit_rs, hit_rt;
  logic [TNEW_W-1:0] tnew_rs, tnew_rt;
  logic [SEL_W-1:0]  idx_rs, idx_rt;
  logic              haz_rs, haz_rt, haz_m, mdu_active;

  // Scanning from oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    hit_rs  = 1'b0;
    hit_rt  = 1'b0;
    tnew_rs = '0;
    tnew_rt = '0;
    idx_rs  = '0;
    idx_rt  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && (addr_q[k] == D_rs) && (D_rs != 5'd0)) begin
        hit_rs  = 1'b1;
        tnew_rs = tnew_q[k];
        idx_rs  = SEL_W'(k + 1);
      end
      if (valid_q[k] && (addr_q[k] == D_rt) && (D_rt != 5'd0)) begin
        hit_rt  = 1'b1;
        tnew_rt = tnew_q[k];
        idx_rt  = SEL_W'(k + 1);
      end
    end
  end

  assign haz_rs     = (D_TuseRs != C_TUSE_NONE) && hit_rs && (tnew_rs > D_TuseRs);
  assign haz_rt     = (D_TuseRt != C_TUSE_NONE) && hit_rt && (tnew_rt > D_TuseRt);
  assign fwdSelRs   = (hit_rs && (tnew_rs == '0)) ? idx_rs : '0;
  assign fwdSelRt   = (hit_rt && (tnew_rt == '0)) ? idx_rt : '0;

  assign mdu_active = (mdu_q == C_MDU_MULT) || (mdu_q == C_MDU_DIV);
  assign mduBusy    = (busy_q != '0) || mdu_active;
  assign haz_m      = (D_mduOp != 2'b00) && mduBusy;
  assign stall      = haz_rs || haz_rt || haz_m;
  assign stallCount = stall_cnt_q;

  always_comb begin
    busy_d = busy_q;
    if (mdu_active && (busy_q == '0)) begin
      busy_d = (mdu_q == C_MDU_MULT) ? C_CNT_W'(MULT_CYCLES) : C_CNT_W'(DIV_CYCLES);
    end else if (busy_q != '0) begin
      busy_d = busy_q - C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      mdu_q       <= 2'b00;
      busy_q      <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= !stall && D_writeReg_EN && (D_dst != 5'd0);
      addr_q[0]  <= D_dst;
      tnew_q[0]  <= D_Tnew;
      mdu_q      <= stall ? 2'b00 : D_mduOp;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        addr_q[k]  <= addr_q[k-1];
        tnew_q[k]  <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TNEW_W'(1);
      end
      busy_q <= busy_d;
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire
